secuenciador_texto_vga: RTL

- Character-cell fetch controller for the VGA text path.
- Holds a small on-chip text buffer: a window of character codes placed on the 8x16 tile grid.
- Sequences the shared synchronous font ROM once per tile, prefetching the next tile's row pattern, and serializes it into the pixel bit stream (bit_fuente).
- Arbitrates the single-port text buffer between display prefetch (priority) and a host write port with valid/ready handshake. Sits between the VGA sync counters and the colour mux.

---
 rtl/txt_vga_pkg.sv | 20 ++
 rtl/buffer_texto.sv | 35 +++
 rtl/secuenciador_texto_vga.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/txt_vga_pkg.sv
// Shared definitions for the VGA text fetch path: fetch FSM states,
// tile geometry and the width helper for window cell indices.
package txt_vga_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_TXT = 2'd1,
    RD_ROM = 2'd2,
    CAPT   = 2'd3
  } fetch_state_t;

  localparam int TILE_W = 8;
  localparam int TILE_H = 16;

  // Number of bits needed to index every cell of a cols x rows window
  function automatic int win_idx_w(input int cols, input int rows);
    return (cols * rows > 1) ? $clog2(cols * rows) : 1;
  endfunction

endpackage

// File: rtl/buffer_texto.sv
// Text buffer for the VGA text window: one character code per cell,
// row-major, cleared to glyph 0 (blank) by a synchronous active-low reset.
// One write port, one combinational read port.
module buffer_texto #(
  parameter int CHAR_W = 2,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [CHAR_W-1:0] rd_data
);

  logic [CHAR_W-1:0] celdas [DEPTH];

  // Clear every cell on reset, otherwise store the write data when enabled
  always_ff @(posedge reloj) begin
    if (!resetM) begin
      for (int i = 0; i < DEPTH; i++) celdas[i] <= '0;
    end else if (we && (int'(wr_addr) < DEPTH)) begin
      celdas[wr_addr] <= wr_data;
    end
  end

  // Combinational read; an index past the last cell reads as blank
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < DEPTH) rd_data = celdas[rd_addr];
  end

endmodule

// File: rtl/secuenciador_texto_vga.sv
// Character-cell fetch controller for the VGA text path.
// Once per tile it reads the next tile's character from the text buffer,
// fetches the glyph line from the shared font ROM and hands the row to the
// pixel serializer. The host write port only gets the buffer when the
// fetch FSM is idle and not launching.
// Optional build macro CURSOR_EN adds a blinking inverted cursor cell.
module secuenciador_texto_vga
  import txt_vga_pkg::*;
#(
  parameter int CHAR_W   = 2,
  parameter int WIN_X    = 50,
  parameter int WIN_Y    = 16,
  parameter int WIN_COLS = 8,
  parameter int WIN_ROWS = 2,
  parameter int H_TOTAL  = 800,
  localparam int N_CELLS = WIN_COLS * WIN_ROWS,
  localparam int IDX_W   = win_idx_w(WIN_COLS, WIN_ROWS)
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              pix_tick,
  input  logic              video_on,
  input  logic [9:0]        Qh,
  input  logic [9:0]        Qv,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [CHAR_W-1:0] wr_char,
  output logic              wr_err,
`ifdef CURSOR_EN
  input  logic [IDX_W-1:0]  cursor_addr,
  input  logic              cursor_on,
`endif
  output logic [CHAR_W+3:0] font_addr,
  output logic              font_en,
  input  logic [7:0]        font_data,
  output logic              bit_fuente
);

  fetch_state_t      estado;
  logic [6:0]        ncol_now;
  logic [6:0]        ncol_q;
  logic [5:0]        fila_q;
  logic [3:0]        linea_q;
  logic              skip_q;
  logic [7:0]        next_row;
  logic [7:0]        cur_row;
  logic              launch;
  int                col_i;
  int                fila_i;
  logic              in_win;
  logic [IDX_W-1:0]  rd_idx;
  logic [CHAR_W-1:0] rd_char;
  logic [CHAR_W-1:0] char_sel;
  logic              wr_accept;
  logic              wr_in_range;
  logic              invertir;

  // Next tile column, wrapping to column 0 after the last column of the line
  always_comb begin
    ncol_now = Qh[9:3] + 7'd1;
    if (int'(Qh[9:3]) >= (H_TOTAL / TILE_W) - 1) ncol_now = '0;
  end

  assign launch      = pix_tick && (Qh[2:0] == 3'd0) && (estado == IDLE);
  assign wr_ready    = resetM && (estado == IDLE) && !launch;
  assign wr_accept   = wr_valid && wr_ready;
  assign wr_in_range = int'(wr_addr) < N_CELLS;

  // Decide whether the captured tile lies inside the text window and find its cell
  always_comb begin
    col_i    = int'(ncol_q);
    fila_i   = int'(fila_q);
    in_win   = (col_i >= WIN_X) && (col_i < WIN_X + WIN_COLS) &&
               (fila_i >= WIN_Y) && (fila_i < WIN_Y + WIN_ROWS);
    rd_idx   = '0;
    char_sel = '0;
    if (in_win) begin
      rd_idx   = IDX_W'((fila_i - WIN_Y) * WIN_COLS + (col_i - WIN_X));
      char_sel = rd_char;
    end
  end

  buffer_texto #(
    .CHAR_W (CHAR_W),
    .DEPTH  (N_CELLS),
    .IDX_W  (IDX_W)
  ) u_buffer (
    .reloj   (reloj),
    .resetM  (resetM),
    .we      (wr_accept && wr_in_range),
    .wr_addr (wr_addr),
    .wr_data (wr_char),
    .rd_addr (rd_idx),
    .rd_data (rd_char)
  );

`ifdef CURSOR_EN
  logic [5:0] frame_cnt;
  logic       cursor_hit_q;

  // Frame counter advances once per frame; bit 5 is the blink phase
  always_ff @(posedge reloj) begin
    if (!resetM) frame_cnt <= '0;
    else if (pix_tick && (Qh == 10'd0) && (Qv == 10'd0)) frame_cnt <= frame_cnt + 6'd1;
  end

  // Remember whether the tile being fetched is the cursor cell
  always_ff @(posedge reloj) begin
    if (!resetM) cursor_hit_q <= 1'b0;
    else if (estado == RD_TXT) cursor_hit_q <= in_win && (rd_idx == cursor_addr);
  end

  assign invertir = cursor_on && frame_cnt[5] && cursor_hit_q;
`else
  assign invertir = 1'b0;
`endif

  // Fetch FSM: buffer read, ROM strobe, row capture; reset abandons any fetch
  always_ff @(posedge reloj) begin
    if (!resetM) begin
      estado    <= IDLE;
      ncol_q    <= '0;
      fila_q    <= '0;
      linea_q   <= '0;
      skip_q    <= 1'b0;
      font_en   <= 1'b0;
      font_addr <= '0;
      next_row  <= '0;
    end else begin
      case (estado)
        IDLE: begin
          if (launch) begin
            ncol_q  <= ncol_now;
            fila_q  <= Qv[9:4];
            linea_q <= Qv[3:0];
            estado  <= RD_TXT;
          end
        end
        RD_TXT: begin
          skip_q    <= !in_win;
          font_addr <= {char_sel, linea_q};
          font_en   <= in_win;
          estado    <= RD_ROM;
        end
        RD_ROM: begin
          font_en <= 1'b0;
          estado  <= CAPT;
        end
        CAPT: begin
          if (skip_q)        next_row <= 8'h00;
          else if (invertir) next_row <= ~font_data;
          else               next_row <= font_data;
          estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

  // Serializer: hand over the prefetched row at the tile end, emit one pixel per tick
  always_ff @(posedge reloj) begin
    if (!resetM) begin
      cur_row    <= '0;
      bit_fuente <= 1'b0;
    end else if (pix_tick) begin
      if (Qh[2:0] == 3'd7) cur_row <= next_row;
      bit_fuente <= video_on ? cur_row[3'd7 - Qh[2:0]] : 1'b0;
    end
  end

  // Sticky error flag for accepted writes outside the buffer
  always_ff @(posedge reloj) begin
    if (!resetM) wr_err <= 1'b0;
    else if (wr_accept && !wr_in_range) wr_err <= 1'b1;
  end

endmodule
